// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM encoding, flag bit
// positions and register-file geometry.
package alu_seq_pkg;

   localparam int RegDepth = 8;
   localparam int RegWidth = 32;
   localparam int RegAddrW = 3;
   localparam int FlagW    = 4;

   localparam int FlagV = 3;
   localparam int FlagC = 2;
   localparam int FlagZ = 1;
   localparam int FlagN = 0;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_ORR = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_MOV = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StResp  = 2'd2
   } seqStateE;

   function automatic logic isValidOp(input logic [3:0] op);
      return (op <= OP_SHR);
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x32 register file: two async read ports, R0 hardwired to zero, and a write
// path where the ALU writeback beats a same-address host write.
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [RegAddrW-1:0] raddrA_i,
   output logic [RegWidth-1:0] rdataA_o,
   input  logic [RegAddrW-1:0] raddrB_i,
   output logic [RegWidth-1:0] rdataB_o,
   input  logic                wbEn_i,
   input  logic [RegAddrW-1:0] wbAddr_i,
   input  logic [RegWidth-1:0] wbData_i,
   input  logic                hostEn_i,
   input  logic [RegAddrW-1:0] hostAddr_i,
   input  logic [RegWidth-1:0] hostData_i
);

   logic [RegWidth-1:0] mem_q [1:RegDepth-1];

   assign rdataA_o = (raddrA_i == '0) ? '0 : mem_q[raddrA_i];
   assign rdataB_o = (raddrB_i == '0) ? '0 : mem_q[raddrB_i];

   // Writeback and host write land in the same cycle when they target
   // different entries; on a clash the writeback wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < RegDepth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < RegDepth; i++) begin
            if (wbEn_i && (wbAddr_i == RegAddrW'(i))) begin
               mem_q[i] <= wbData_i;
            end else if (hostEn_i && (hostAddr_i == RegAddrW'(i))) begin
               mem_q[i] <= hostData_i;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that feeds an external combinational ALU from a register file.
// Define ALU_SEQ_OPCOUNT_EN to build the saturating completed-op counter.
module alu_seq_ctrl
   import alu_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                ReqValid,
   output logic                ReqReady,
   input  logic [3:0]          ReqOp,
   input  logic [RegAddrW-1:0] ReqRd,
   input  logic [RegAddrW-1:0] ReqRa,
   input  logic [RegAddrW-1:0] ReqRb,
   input  logic                ReqUseFlag,
   output logic [RegWidth-1:0] ALUA,
   output logic [RegWidth-1:0] ALUB,
   output logic [3:0]          ALUControl,
   output logic                ALUFlagIn,
   input  logic [RegWidth-1:0] ALUResult,
   input  logic [FlagW-1:0]    ALUFlags,
   output logic                RspValid,
   input  logic                RspReady,
   output logic [RegWidth-1:0] RspData,
   output logic [FlagW-1:0]    RspFlags,
   output logic                RspErr,
   input  logic                WrEn,
   input  logic [RegAddrW-1:0] WrAddr,
   input  logic [RegWidth-1:0] WrData,
   output logic [15:0]         OpCount
);

   seqStateE            state_q;
   logic [RegAddrW-1:0] rd_q;
   logic [RegWidth-1:0] aluA_q, aluB_q, rspData_q;
   logic [RegWidth-1:0] rdDataA, rdDataB;
   logic [3:0]          aluCtl_q;
   logic [FlagW-1:0]    flag_q, rspFlags_q;
   logic                aluFlagIn_q, rspErr_q, rspValid_q;
   logic                wbEn;

   assign wbEn = (state_q == StIssue) && isValidOp(aluCtl_q);

   alu_seq_regfile uRegfile (
      .clk        (clk),
      .rst        (rst),
      .raddrA_i   (ReqRa),
      .rdataA_o   (rdDataA),
      .raddrB_i   (ReqRb),
      .rdataB_o   (rdDataB),
      .wbEn_i     (wbEn),
      .wbAddr_i   (rd_q),
      .wbData_i   (ALUResult),
      .hostEn_i   (WrEn),
      .hostAddr_i (WrAddr),
      .hostData_i (WrData)
   );

   // The ALU operand registers double as the accept-time latches, so they
   // only change on accept and hold their value through RESP and IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rd_q        <= '0;
         aluA_q      <= '0;
         aluB_q      <= '0;
         aluCtl_q    <= '0;
         aluFlagIn_q <= 1'b0;
         flag_q      <= '0;
         rspData_q   <= '0;
         rspFlags_q  <= '0;
         rspErr_q    <= 1'b0;
         rspValid_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (ReqValid) begin
                  rd_q        <= ReqRd;
                  aluCtl_q    <= ReqOp;
                  aluA_q      <= rdDataA;
                  aluB_q      <= rdDataB;
                  aluFlagIn_q <= ReqUseFlag ? flag_q[FlagC] : 1'b0;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               if (isValidOp(aluCtl_q)) begin
                  rspData_q  <= ALUResult;
                  rspFlags_q <= ALUFlags;
                  flag_q     <= ALUFlags;
                  rspErr_q   <= 1'b0;
               end else begin
                  rspData_q  <= '0;
                  rspFlags_q <= flag_q;
                  rspErr_q   <= 1'b1;
               end
               rspValid_q <= 1'b1;
               state_q    <= StResp;
            end
            StResp: begin
               if (RspReady) begin
                  rspValid_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef ALU_SEQ_OPCOUNT_EN
   logic [15:0] opCount_q;

   // Counts only successful completions and sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opCount_q <= '0;
      end else if ((state_q == StResp) && RspReady && !rspErr_q
                   && (opCount_q != 16'hFFFF)) begin
         opCount_q <= opCount_q + 16'd1;
      end
   end

   assign OpCount = opCount_q;
`else
   assign OpCount = '0;
`endif

   assign ReqReady   = (state_q == StIdle);
   assign ALUA       = aluA_q;
   assign ALUB       = aluB_q;
   assign ALUControl = aluCtl_q;
   assign ALUFlagIn  = aluFlagIn_q;
   assign RspValid   = rspValid_q;
   assign RspData    = rspData_q;
   assign RspFlags   = rspFlags_q;
   assign RspErr     = rspErr_q;

endmodule
